// File: rtl/id_operand_stage.sv
// Decode-side operand stage: resolves RS/RT against in-flight EX/MEM results,
// inserts load-use bubbles and feeds the ID/EX register. Optional WB forwarding via RF_BYPASS_EN.
module id_operand_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int SCW = 16
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           ID_VALID,
    input  logic [AW-1:0]  ID_RSaddr,
    input  logic [AW-1:0]  ID_RTaddr,
    input  logic           ID_USES_RS,
    input  logic           ID_USES_RT,
    input  logic [AW-1:0]  ID_DEST,
    input  logic           ID_REGWRITE,
    input  logic           ID_IS_LOAD,
    input  logic [DW-1:0]  RF_RS,
    input  logic [DW-1:0]  RF_RT,
    input  logic [DW-1:0]  EX_RESULT,
    input  logic [AW-1:0]  MEM_DEST,
    input  logic           MEM_REGWRITE,
    input  logic [DW-1:0]  MEM_RESULT,
    input  logic [AW-1:0]  WB_DEST,
    input  logic           WB_REGWRITE,
    input  logic [DW-1:0]  WB_RESULT,
    input  logic           FLUSH,
    input  logic           EX_HOLD,
    output logic           STALL,
    output logic           EX_VALID,
    output logic [DW-1:0]  EX_RS,
    output logic [DW-1:0]  EX_RT,
    output logic [AW-1:0]  EX_DEST,
    output logic           EX_REGWRITE,
    output logic           EX_IS_LOAD,
    output logic [SCW-1:0] STALL_CNT
);

    logic          load_use;
    logic          ex_fwd_ok;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // A load in EX has no data yet, so it never forwards; it stalls instead.
    assign ex_fwd_ok = EX_VALID & EX_REGWRITE & ~EX_IS_LOAD;

`ifndef RF_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{WB_DEST, WB_REGWRITE, WB_RESULT};
`endif

    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] addr,
                                              input logic [DW-1:0] rf_data);
        logic [DW-1:0] val;
        if (addr == '0)
            val = '0;
        else if (ex_fwd_ok && (EX_DEST == addr))
            val = EX_RESULT;
        else if (MEM_REGWRITE && (MEM_DEST == addr))
            val = MEM_RESULT;
`ifdef RF_BYPASS_EN
        else if (WB_REGWRITE && (WB_DEST == addr))
            val = WB_RESULT;
`endif
        else
            val = rf_data;
        return val;
    endfunction

    always_comb begin
        rs_fwd = resolve(ID_RSaddr, RF_RS);
        rt_fwd = resolve(ID_RTaddr, RF_RT);
    end

    always_comb begin
        load_use = ID_VALID & EX_VALID & EX_IS_LOAD & (EX_DEST != '0) &
                   ((ID_USES_RS & (ID_RSaddr == EX_DEST)) |
                    (ID_USES_RT & (ID_RTaddr == EX_DEST)));
    end

    assign STALL = load_use | EX_HOLD;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            EX_VALID    <= 1'b0;
            EX_RS       <= '0;
            EX_RT       <= '0;
            EX_DEST     <= '0;
            EX_REGWRITE <= 1'b0;
            EX_IS_LOAD  <= 1'b0;
            STALL_CNT   <= '0;
        end else begin
            if (load_use && !EX_HOLD && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + SCW'(1);
            if (!EX_HOLD) begin
                // Bubble keeps the operand/dest registers; only the qualifiers drop.
                if (FLUSH || load_use) begin
                    EX_VALID    <= 1'b0;
                    EX_REGWRITE <= 1'b0;
                    EX_IS_LOAD  <= 1'b0;
                end else begin
                    EX_VALID    <= ID_VALID;
                    EX_REGWRITE <= ID_REGWRITE & ID_VALID;
                    EX_IS_LOAD  <= ID_IS_LOAD & ID_VALID;
                    EX_DEST     <= ID_DEST;
                    EX_RS       <= rs_fwd;
                    EX_RT       <= rt_fwd;
                end
            end
        end
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage that sits directly downstream of the 32x32 register file.
- Takes the combinational RS/RT read data from the register file and resolves them against in-flight results from EX, MEM and (optionally) WB.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands and control into the ID/EX pipeline register that feeds the ALU.

Parameters:
- DW, 32, datapath width (operands, results).
- AW, 5, register specifier width.
- SCW, 16, stall-counter width.

Ports:
- CLK  input  1  pipeline clock, all state updates on posedge
- RESET_N  input  1  reset, synchronous, active-low
- ID_VALID  input  1  decode slot holds a real instruction
- ID_RSaddr  input  AW  source specifier (also drives register file RSaddr)
- ID_RTaddr  input  AW  target specifier (also drives register file RTaddr)
- ID_USES_RS  input  1  instruction reads RS
- ID_USES_RT  input  1  instruction reads RT
- ID_DEST  input  AW  destination specifier
- ID_REGWRITE  input  1  instruction writes a register
- ID_IS_LOAD  input  1  instruction is a load
- RF_RS  input  DW  register file RS read data
- RF_RT  input  DW  register file RT read data
- EX_RESULT  input  DW  combinational ALU result of the instruction in EX
- MEM_DEST  input  AW  destination of the instruction in MEM
- MEM_REGWRITE  input  1  MEM instruction writes a register
- MEM_RESULT  input  DW  result available in MEM
- WB_DEST  input  AW  write-back destination (register file RDaddr)
- WB_REGWRITE  input  1  write-back enable
- WB_RESULT  input  DW  write-back data (register file RD)
- FLUSH  input  1  kill the decode-slot instruction (branch redirect)
- EX_HOLD  input  1  downstream stall; freeze the ID/EX register
- STALL  output  1  freeze fetch/decode this cycle
- EX_VALID  output  1  ID/EX register holds a real instruction
- EX_RS  output  DW  resolved source operand
- EX_RT  output  DW  resolved target operand
- EX_DEST  output  AW  registered destination
- EX_REGWRITE  output  1  registered write enable
- EX_IS_LOAD  output  1  registered load flag
- STALL_CNT  output  SCW  load-use stall cycles counted since reset

Behaviour:
- Reset: RESET_N low at posedge clears EX_VALID, EX_RS, EX_RT, EX_DEST, EX_REGWRITE, EX_IS_LOAD and STALL_CNT to 0. Reset overrides every other input. Reset asserted mid-stall discards the held instruction.
- Load-use hazard, combinational. LOAD_USE = ID_VALID & EX_VALID & EX_IS_LOAD & (EX_DEST!=0) & ((ID_USES_RS & ID_RSaddr==EX_DEST) | (ID_USES_RT & ID_RTaddr==EX_DEST)).
- STALL = LOAD_USE | EX_HOLD. STALL is 0 after reset.
- Forward mux per operand, evaluated independently for RS and RT. Priority order:
  1. Specifier is 0 → value 0; never forwarded.
  2. EX match: EX_VALID & EX_REGWRITE & !EX_IS_LOAD & EX_DEST==addr → EX_RESULT.
  3. MEM match: MEM_REGWRITE & MEM_DEST==addr → MEM_RESULT.
  4. WB match: only with RF_BYPASS_EN (see Optional Feature).
  5. Otherwise → RF_RS / RF_RT.
- The same specifier on RS and RT yields identical values.
- Posedge update order, first match wins:
  1. Reset.
  2. EX_HOLD: all EX_* registers hold; FLUSH is ignored by this block (upstream owns killing the ID slot).
  3. FLUSH: bubble, i.e. EX_VALID=0, EX_REGWRITE=0, EX_IS_LOAD=0; EX_RS/EX_RT/EX_DEST hold.
  4. LOAD_USE: bubble, same as FLUSH. The ID instruction is re-presented next cycle and then forwards from MEM.
  5. Capture: EX_VALID=ID_VALID, EX_REGWRITE=ID_REGWRITE&ID_VALID, EX_IS_LOAD=ID_IS_LOAD&ID_VALID, EX_DEST=ID_DEST, EX_RS/EX_RT=forwarded values.
- Latency: one cycle from ID inputs to EX_* outputs. A load-use hazard costs exactly one bubble.
- STALL_CNT increments by 1 on each posedge where LOAD_USE=1 and EX_HOLD=0. It saturates at all-ones and never wraps.
- Outputs EX_* are pure registers; STALL is combinational from registered state and ID inputs only, with no path from EX_RESULT.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: add a WB forward level between MEM and the register file. Condition is WB_REGWRITE & WB_DEST==addr & addr!=0, and the value is WB_RESULT. This covers same-cycle write/read of the register file, whose write lands only at the clock edge.
- Undefined: no WB level; the design relies on a register file with write-before-read timing, and WB_* inputs are unused.

Test Plan:
- Reset → all EX_* = 0, STALL=0, STALL_CNT=0. Drive RESET_N=0 during an active stall → bubble cleared next edge.
- ADD r3 in EX (EX_RESULT=0x11), ID reads RS=r3 while RF_RS=0xDEAD → EX_RS=0x11 next cycle. With r3 also in MEM (0x22), EX still wins → 0x11.
- LW r5 in EX, ID uses RT=r5 → STALL=1 for one cycle, EX_VALID=0 for one cycle, STALL_CNT=1. The repeated ID then forwards MEM_RESULT=0x55 → EX_RT=0x55.
- ID reads r0 with EX_DEST=0, EX_REGWRITE=1, EX_RESULT=0xFFFF → EX_RS=0. A load to r0 in EX causes no stall.
- EX_HOLD=1 with FLUSH=1 for 3 cycles → EX_* frozen, STALL=1, STALL_CNT unchanged. Release with FLUSH=1 → EX_VALID=0.
- RF_BYPASS_EN: WB writes r7=0xABCD, ID reads r7, RF_RT=0x0 → EX_RT=0xABCD. Without the macro → EX_RT=0x0.
